// File: rtl/seq_pkg.sv
// Shared definitions for the programmable serial sequence detector:
// FSM state encoding and default widths.
package seq_pkg;

  // FILL: still collecting the first WIDTH bits since the last restart.
  // ARMED_ST: a full window of WIDTH bits is present.
  typedef enum logic {
    FILL     = 1'b0,
    ARMED_ST = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count increments, holding at all-ones, cleared on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector with masked compare, optional
// overlapping matches and a saturating match counter.
module seq_detect_prog
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_in,
  input  logic             d_valid,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] mask,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  // Fill counter must be able to hold the value WIDTH itself.
  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(WIDTH - 1);
  localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(WIDTH);

  state_t            state;
  logic [WIDTH-1:0]  history;
  logic [FILL_W-1:0] fill_cnt;
  logic [WIDTH-1:0]  pattern_r;
  logic [WIDTH-1:0]  mask_r;
  logic              overlap_r;

  logic [WIDTH-1:0]  hist_next;
  logic              window_full;
  logic              hit;

  // Compare the post-shift window; the sample that completes the first
  // full window is already eligible. LOAD discards the sample entirely.
  always_comb begin
    hist_next   = {history[WIDTH-2:0], d_in};
    window_full = (state == ARMED_ST) || (fill_cnt == LAST_FILL);
    hit         = d_valid && !load && window_full &&
                  (((hist_next ^ pattern_r) & ~mask_r) == '0);
  end

  // Detector FSM: configuration capture, history shifting, fill tracking
  // and the registered match pulse / armed flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      history   <= '0;
      fill_cnt  <= '0;
      pattern_r <= '0;
      mask_r    <= '0;
      overlap_r <= 1'b1;
      match     <= 1'b0;
      armed     <= 1'b0;
    end else if (load) begin
      pattern_r <= pattern;
      mask_r    <= mask;
      overlap_r <= overlap;
      state     <= FILL;
      history   <= '0;
      fill_cnt  <= '0;
      match     <= 1'b0;
      armed     <= 1'b0;
    end else if (d_valid) begin
      match <= hit;
      if (hit && !overlap_r) begin
        // Non-overlapping mode: a match restarts collection from scratch.
        state    <= FILL;
        history  <= '0;
        fill_cnt <= '0;
        armed    <= 1'b0;
      end else begin
        history <= hist_next;
        if (state == FILL) begin
          if (fill_cnt == LAST_FILL) begin
            state    <= ARMED_ST;
            fill_cnt <= FULL_FILL;
            armed    <= 1'b1;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
      end
    end else begin
      match <= 1'b0;
    end
  end

  // Match counter shares the sample edge with the match pulse so both
  // outputs change together.
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .inc  (hit),
    .cnt  (match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed testbench for seq_detect_prog: one task per scenario, inline
// comparisons against hand-computed expectations.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       d_in = 1'b0;
  logic       d_valid = 1'b0;
  logic       load = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [7:0] mask = 8'h00;
  logic       overlap = 1'b1;
  logic       cnt_clr = 1'b0;

  logic       match1, armed1;
  logic [7:0] cnt1;
  logic       match2, armed2;
  logic [1:0] cnt2;

  int checks = 0;
  int failures = 0;
  int nmatch;

  always #5 clk = ~clk;

  seq_detect_prog #(.WIDTH(8), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_valid(d_valid), .load(load),
    .pattern(pattern), .mask(mask), .overlap(overlap), .cnt_clr(cnt_clr),
    .match(match1), .match_cnt(cnt1), .armed(armed1)
  );

  seq_detect_prog #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_valid(d_valid), .load(load),
    .pattern(pattern), .mask(mask), .overlap(overlap), .cnt_clr(cnt_clr),
    .match(match2), .match_cnt(cnt2), .armed(armed2)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_load(input logic [7:0] p, input logic [7:0] m, input logic ov);
    @(negedge clk);
    load = 1'b1; pattern = p; mask = m; overlap = ov;
    @(posedge clk); #1;
    load = 1'b0;
    $display("txn load pattern=%h mask=%h overlap=%0b armed=%0b", p, m, ov, armed1);
  endtask

  // One valid sample; outputs are observed #1 after the sampling edge.
  task automatic send(input logic b, input logic clr);
    @(negedge clk);
    d_in = b; d_valid = 1'b1; cnt_clr = clr;
    @(posedge clk); #1;
    d_valid = 1'b0; cnt_clr = 1'b0;
    $display("txn sample d_in=%0b clr=%0b m1=%0b c1=%0d a1=%0b m2=%0b c2=%0d",
             b, clr, match1, cnt1, armed1, match2, cnt2);
  endtask

  task automatic idle();
    @(negedge clk);
    d_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({match1, armed1, cnt1, match2, armed2, cnt2} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs got m=%0b a=%0b c=%0d m2=%0b a2=%0b c2=%0d want all 0",
               match1, armed1, cnt1, match2, armed2, cnt2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Power-on configuration: pattern 0, mask 0 -> eight zeros must match.
    for (int i = 0; i < 8; i++) send(1'b0, 1'b0);
    checks++;
    if (match1 !== 1'b1 || cnt1 !== 8'd1) begin
      failures++;
      $display("FAIL reset_default_pattern got m=%0b c=%0d want m=1 c=1", match1, cnt1);
    end
  endtask

  task automatic test_basic();
    logic [7:0] v;
    v = 8'hB6;
    do_reset();
    do_load(8'hB6, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(v[7-i], 1'b0);
      if (i < 7) begin
        checks++;
        if (match1 !== 1'b0 || armed1 !== 1'b0) begin
          failures++;
          $display("FAIL basic_fill_%0d got m=%0b a=%0b want m=0 a=0", i, match1, armed1);
        end
      end
    end
    checks++;
    if (match1 !== 1'b1 || armed1 !== 1'b1 || cnt1 !== 8'd1) begin
      failures++;
      $display("FAIL basic_match got m=%0b a=%0b c=%0d want m=1 a=1 c=1", match1, armed1, cnt1);
    end
    idle();
    checks++;
    if (match1 !== 1'b0 || cnt1 !== 8'd1) begin
      failures++;
      $display("FAIL basic_pulse_width got m=%0b c=%0d want m=0 c=1", match1, cnt1);
    end
  endtask

  task automatic test_overlap();
    do_reset();
    do_load(8'hAA, 8'h00, 1'b1);
    nmatch = 0;
    for (int i = 0; i < 10; i++) begin
      send((i % 2) == 0, 1'b0);
      if (match1) nmatch++;
    end
    checks++;
    if (nmatch != 2 || cnt1 !== 8'd2) begin
      failures++;
      $display("FAIL overlap_on got matches=%0d c=%0d want 2 and 2", nmatch, cnt1);
    end
    do_reset();
    do_load(8'hAA, 8'h00, 1'b0);
    nmatch = 0;
    for (int i = 0; i < 10; i++) begin
      send((i % 2) == 0, 1'b0);
      if (match1) nmatch++;
    end
    checks++;
    if (nmatch != 1 || cnt1 !== 8'd1 || armed1 !== 1'b0) begin
      failures++;
      $display("FAIL overlap_off got matches=%0d c=%0d a=%0b want 1, 1, a=0", nmatch, cnt1, armed1);
    end
  endtask

  task automatic test_mask();
    logic [7:0] s [2];
    s[0] = 8'b1010_0110;
    s[1] = 8'b1010_1001;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      do_load(8'hA0, 8'h0F, 1'b1);
      nmatch = 0;
      for (int i = 0; i < 8; i++) begin
        send(s[k][7-i], 1'b0);
        if (match1) nmatch++;
      end
      checks++;
      if (nmatch != 1 || match1 !== 1'b1) begin
        failures++;
        $display("FAIL mask_stream_%0d got matches=%0d last_m=%0b want 1 and 1", k, nmatch, match1);
      end
    end
    checks++;
    if (cnt1 !== 8'd2) begin
      failures++;
      $display("FAIL mask_count got c=%0d want 2", cnt1);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] v;
    v = 8'hB6;
    do_reset();
    do_load(8'hB6, 8'h00, 1'b1);
    nmatch = 0;
    for (int i = 0; i < 8; i++) begin
      send(v[7-i], 1'b0);
      if (match1) nmatch++;
      for (int g = 0; g < 3; g++) begin
        idle();
        checks++;
        if (match1 !== 1'b0) begin
          failures++;
          $display("FAIL gap_%0d_%0d got m=%0b want 0", i, g, match1);
        end
      end
    end
    checks++;
    if (nmatch != 1 || cnt1 !== 8'd1 || armed1 !== 1'b1) begin
      failures++;
      $display("FAIL gap_result got matches=%0d c=%0d a=%0b want 1, 1, a=1", nmatch, cnt1, armed1);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    do_load(8'h00, 8'hFF, 1'b1);
    for (int i = 0; i < 12; i++) send(i[0], 1'b0);
    checks++;
    if (match2 !== 1'b1 || cnt2 !== 2'd3) begin
      failures++;
      $display("FAIL sat_count got m=%0b c=%0d want m=1 c=3", match2, cnt2);
    end
    send(1'b1, 1'b1);
    checks++;
    if (match2 !== 1'b1 || cnt2 !== 2'd0) begin
      failures++;
      $display("FAIL sat_clr_wins got m=%0b c=%0d want m=1 c=0", match2, cnt2);
    end
    send(1'b0, 1'b0);
    checks++;
    if (cnt2 !== 2'd1) begin
      failures++;
      $display("FAIL sat_after_clr got c=%0d want 1", cnt2);
    end
  endtask

  task automatic test_abort();
    logic [7:0] v;
    v = 8'hB6;
    // LOAD pulse before the final bit
    do_reset();
    do_load(8'hB6, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) send(v[7-i], 1'b0);
    do_load(8'hB6, 8'h00, 1'b1);
    send(v[0], 1'b0);
    checks++;
    if (match1 !== 1'b0 || armed1 !== 1'b0) begin
      failures++;
      $display("FAIL abort_load got m=%0b a=%0b want 0 0", match1, armed1);
    end
    // Reset pulse before the final bit
    do_load(8'hB6, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) send(v[7-i], 1'b0);
    do_reset();
    send(v[0], 1'b0);
    checks++;
    if (match1 !== 1'b0 || armed1 !== 1'b0 || cnt1 !== 8'd0) begin
      failures++;
      $display("FAIL abort_reset got m=%0b a=%0b c=%0d want 0 0 0", match1, armed1, cnt1);
    end
    // LOAD together with a valid sample: the sample is dropped
    do_load(8'hB6, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) send(v[7-i], 1'b0);
    @(negedge clk);
    load = 1'b1; d_valid = 1'b1; d_in = v[0];
    @(posedge clk); #1;
    load = 1'b0; d_valid = 1'b0;
    checks++;
    if (match1 !== 1'b0 || armed1 !== 1'b0) begin
      failures++;
      $display("FAIL load_vs_valid got m=%0b a=%0b want 0 0", match1, armed1);
    end
    nmatch = 0;
    for (int i = 0; i < 8; i++) begin
      send(v[7-i], 1'b0);
      if (match1) nmatch++;
    end
    checks++;
    if (nmatch != 1 || match1 !== 1'b1) begin
      failures++;
      $display("FAIL load_vs_valid_refill got matches=%0d last_m=%0b want 1 and 1", nmatch, match1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_mask();
    test_gaps();
    test_saturate();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
